// File: rtl/logic_sweep_checker_pkg.sv
// rtl/logic_sweep_checker_pkg.sv - shared types, function codes and NAND helpers
//
// Purpose: state encoding for the sweep FSM, the named truth-table codes
// (bit {a,b} of the code is the result for inputs a,b) and the NAND
// primitives used to build the gate-network path.
// Ports: none (package).
package logic_sweep_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] FN_ZERO   = 4'b0000;
  localparam logic [3:0] FN_AND    = 4'b1000;
  localparam logic [3:0] FN_OR     = 4'b1110;
  localparam logic [3:0] FN_XOR    = 4'b0110;
  localparam logic [3:0] FN_NAND   = 4'b0111;
  localparam logic [3:0] FN_NOR    = 4'b0001;
  localparam logic [3:0] FN_IMPL_N = 4'b1011;
  localparam logic [3:0] FN_ONE    = 4'b1111;

  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

  function automatic logic nand3(input logic a, input logic b, input logic c);
    return ~(a & b & c);
  endfunction

  function automatic logic nand4(input logic [3:0] v);
    return ~(&v);
  endfunction

endpackage

// File: rtl/logic_sweep_checker_nand_func_net.sv
// rtl/logic_sweep_checker_nand_func_net.sv - NAND-only realisation of one truth-table bit
//
// Purpose: computes y = func[{a,b}] using NAND gates only, as a NAND-NAND
// sum of minterms where each minterm is enabled by its code bit.
// Ports:
//   func  in  4  truth-table code
//   a, b  in  1  operand bits
//   y     out 1  func[{a,b}]
module nand_func_net
  import logic_sweep_checker_pkg::*;
(
  input  logic [3:0] func,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  logic       a_n;
  logic       b_n;
  logic [3:0] term_n;

  // Inverters as self-NANDs so the network stays single-primitive.
  assign a_n = nand2(a, a);
  assign b_n = nand2(b, b);

  // term_n[m] is low only when minterm m is active and enabled by func[m].
  assign term_n[0] = nand3(func[0], a_n, b_n);
  assign term_n[1] = nand3(func[1], a_n, b);
  assign term_n[2] = nand3(func[2], a,   b_n);
  assign term_n[3] = nand3(func[3], a,   b);

  assign y = nand4(term_n);

endmodule

// File: rtl/logic_sweep_checker.sv
// rtl/logic_sweep_checker.sv - exhaustive sweep comparing NAND network to truth-table lookup
//
// Purpose: on start, walks every {x,y} operand pair (one per clock), evaluates
// the latched function through a NAND gate network and through a direct
// lookup, and counts combinations where they disagree. Optional fault
// injection flips bit 0 of the NAND result at one chosen index.
// Ports:
//   clk, rst          in   clock, async active-high reset
//   start             in   begin a sweep (sampled in IDLE only)
//   func              in   4-bit truth-table code
//   inj_en, inj_idx   in   fault injection enable / combination index
//   busy              out  high during the N sweep cycles
//   done              out  one-cycle end-of-sweep pulse
//   pass              out  1 when the last sweep had no mismatches
//   err_count         out  mismatching combination count
//   first_fail_x/y    out  operands of the first mismatch (0 if none)
module logic_sweep_checker
  import logic_sweep_checker_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         func,
  input  logic               inj_en,
  input  logic [2*WIDTH-1:0] inj_idx,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   first_fail_x,
  output logic [WIDTH-1:0]   first_fail_y
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = 2 * WIDTH + 1;
  localparam logic [IW-1:0] LAST_IDX = '1;

  state_e           state_q, state_d;
  logic [IW-1:0]    index_q, index_d;
  logic [CW-1:0]    err_count_q, err_count_d;
  logic [WIDTH-1:0] first_fail_x_q, first_fail_x_d;
  logic [WIDTH-1:0] first_fail_y_q, first_fail_y_d;
  logic             pass_q, pass_d;
  logic [3:0]       func_q, func_d;
  logic             inj_en_q, inj_en_d;
  logic [IW-1:0]    inj_idx_q, inj_idx_d;

  logic [WIDTH-1:0] cur_x;
  logic [WIDTH-1:0] cur_y;
  logic [WIDTH-1:0] nand_res;
  logic [WIDTH-1:0] nand_chk;
  logic [WIDTH-1:0] expr_res;
  logic             inj_hit;
  logic             mismatch;

  assign cur_x = index_q[IW-1:WIDTH];
  assign cur_y = index_q[WIDTH-1:0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_nand_path
    nand_func_net u_net (
      .func (func_q),
      .a    (cur_x[i]),
      .b    (cur_y[i]),
      .y    (nand_res[i])
    );
  end

  assign inj_hit = inj_en_q && (index_q == inj_idx_q);

  always_comb begin
    expr_res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      expr_res[i] = func_q[{cur_x[i], cur_y[i]}];
    end
    nand_chk    = nand_res;
    nand_chk[0] = nand_res[0] ^ inj_hit;
  end

  // Any differing bit makes the whole combination one mismatch.
  assign mismatch = |(nand_chk ^ expr_res);

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    err_count_d    = err_count_q;
    first_fail_x_d = first_fail_x_q;
    first_fail_y_d = first_fail_y_q;
    pass_d         = pass_q;
    func_d         = func_q;
    inj_en_d       = inj_en_q;
    inj_idx_d      = inj_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          func_d         = func;
          inj_en_d       = inj_en;
          inj_idx_d      = inj_idx;
          index_d        = '0;
          err_count_d    = '0;
          first_fail_x_d = '0;
          first_fail_y_d = '0;
          pass_d         = 1'b0;
          state_d        = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mismatch) begin
          err_count_d = err_count_q + CW'(1);
          if (err_count_q == '0) begin
            first_fail_x_d = cur_x;
            first_fail_y_d = cur_y;
          end
        end
        // The increment wraps to 0 exactly as the sweep leaves RUN.
        index_d = index_q + IW'(1);
        if (index_q == LAST_IDX) begin
          // Resolve pass from the final count so it is already valid
          // while done is high.
          pass_d  = (err_count_d == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      index_q        <= '0;
      err_count_q    <= '0;
      first_fail_x_q <= '0;
      first_fail_y_q <= '0;
      pass_q         <= 1'b0;
      func_q         <= '0;
      inj_en_q       <= 1'b0;
      inj_idx_q      <= '0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      err_count_q    <= err_count_d;
      first_fail_x_q <= first_fail_x_d;
      first_fail_y_q <= first_fail_y_d;
      pass_q         <= pass_d;
      func_q         <= func_d;
      inj_en_q       <= inj_en_d;
      inj_idx_q      <= inj_idx_d;
    end
  end

  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign pass         = pass_q;
  assign err_count    = err_count_q;
  assign first_fail_x = first_fail_x_q;
  assign first_fail_y = first_fail_y_q;

endmodule

// File: tb/tb_logic_sweep_checker.sv
// tb/tb_logic_sweep_checker.sv - scoreboard bench for logic_sweep_checker
module tb_logic_sweep_checker;

  localparam int W  = 2;
  localparam int IW = 2 * W;
  localparam int N  = 1 << IW;

  typedef logic [IW:0]   cnt_t;
  typedef logic [W-1:0]  opd_t;
  typedef logic [IW-1:0] idx_t;

  typedef struct packed {
    cnt_t       err;
    opd_t       fx;
    opd_t       fy;
    logic       pass;
    logic [3:0] func;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] func = 4'd0;
  logic       inj_en = 1'b0;
  idx_t       inj_idx = '0;
  logic       busy;
  logic       done;
  logic       pass;
  cnt_t       err_count;
  opd_t       first_fail_x;
  opd_t       first_fail_y;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_run = 0;

  always #5 clk = ~clk;

  logic_sweep_checker #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .func         (func),
    .inj_en       (inj_en),
    .inj_idx      (inj_idx),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .first_fail_x (first_fail_x),
    .first_fail_y (first_fail_y)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: golden result is the truth-table bit per operand bit pair;
  // the NAND path equals it except at the injected index, where bit 0 flips.
  function automatic exp_t model(input logic [3:0] f, input logic ie, input idx_t ii);
    exp_t e;
    int   fails;
    int   golden;
    int   observed;
    int   x;
    int   y;
    int   sel;
    e     = '0;
    fails = 0;
    e.func = f;
    for (int idx = 0; idx < N; idx++) begin
      x = idx / (1 << W);
      y = idx % (1 << W);
      golden = 0;
      for (int b = 0; b < W; b++) begin
        sel = 2 * ((x >> b) & 1) + ((y >> b) & 1);
        golden = golden | (((int'(f) >> sel) & 1) << b);
      end
      observed = golden;
      if (ie && idx == int'(ii)) observed = observed ^ 1;
      if (observed != golden) begin
        if (fails == 0) begin
          e.fx = opd_t'(x);
          e.fy = opd_t'(y);
        end
        fails++;
      end
    end
    e.err  = cnt_t'(fails);
    e.pass = (fails == 0);
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done pulse, expected none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("err_count", int'(err_count), int'(e.err));
          check("first_fail_x", int'(first_fail_x), int'(e.fx));
          check("first_fail_y", int'(first_fail_y), int'(e.fy));
          check("pass", int'(pass), int'(e.pass));
          check("busy_len", busy_run, N);
          check("busy_in_done", int'(busy), 0);
        end
        busy_run = 0;
      end
    end
  end

  task automatic start_sweep(input logic [3:0] f, input logic ie, input idx_t ii, input bit scramble);
    @(posedge clk);
    #1;
    start   = 1'b1;
    func    = f;
    inj_en  = ie;
    inj_idx = ii;
    exp_q.push_back(model(f, ie, ii));
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) begin
      func    = 4'($urandom);
      inj_en  = 1'($urandom);
      inj_idx = idx_t'($urandom);
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 200);
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", cycles);
    end
  endtask

  initial begin
    int c;
    int gap;
    int dcount;

    // 1. reset with arbitrary inputs
    rst     = 1'b1;
    start   = 1'b1;
    func    = 4'($urandom);
    inj_en  = 1'b1;
    inj_idx = idx_t'($urandom);
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_ffx", int'(first_fail_x), 0);
    check("rst_ffy", int'(first_fail_y), 0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;

    // 2. single clean sweep
    start_sweep(4'b1011, 1'b0, '0, 1'b0);
    wait_done(c);
    check("latency_single", c, N + 1);

    // 3. injected fault, inputs scrambled after latch
    start_sweep(4'b0110, 1'b1, 4'b0101, 1'b1);
    wait_done(c);
    check("latency_inject", c, N + 1);

    // 4. start held, func changed mid-sweep
    @(posedge clk);
    #1;
    start   = 1'b1;
    func    = 4'b1000;
    inj_en  = 1'b0;
    inj_idx = '0;
    exp_q.push_back(model(4'b1000, 1'b0, '0));
    exp_q.push_back(model(4'b0001, 1'b0, '0));
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    func = 4'b0001;
    wait_done(c);
    gap = 0;
    while (!busy && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    check("busy_gap", gap, 2);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(c);

    // 5. reset mid-sweep after an injected error has been counted
    start_sweep(4'b0110, 1'b1, 4'b0011, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_err_count", int'(err_count), 0);
    check("abort_done", int'(done), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    start_sweep(4'b1110, 1'b0, '0, 1'b1);
    wait_done(c);
    check("latency_after_abort", c, N + 1);

    // 6. every function code back to back
    for (int f = 0; f < 16; f++) begin
      start_sweep(4'(f), 1'b0, '0, 1'b1);
      wait_done(c);
      check("latency_code", c, N + 1);
    end

    // randomized sweeps
    repeat (8) begin
      start_sweep(4'($urandom), 1'($urandom), idx_t'($urandom), 1'b1);
      wait_done(c);
      check("latency_random", c, N + 1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, expected finish");
    $fatal(1);
  end

endmodule
